branch_pc_ctrl: RTL and testbench
=================================

Name: branch_pc_ctrl

Overview:
Consumer side of the branch comparator in the core. Takes the comparator's taken/not-taken result `b` for the instruction in EX, together with jump controls, and owns the fetch PC register. Computes the redirect targets, drives a counted squash of the wrong-path instructions in IF/ID, and vectors to a trap address when a target is misaligned.

Parameters:
XLEN, 32, datapath / PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-target trap
FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect (1..7)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline stall; freezes PC, state and counter
br_en  in  1  EX holds a conditional branch (beq/bne/blt/bge/bltu/bgeu)
b  in  1  comparator result, 1 = branch condition true
jal  in  1  EX holds JAL
jalr  in  1  EX holds JALR
pc_ex  in  XLEN  PC of the EX instruction
imm  in  XLEN  sign-extended immediate of the EX instruction
rs1_d  in  XLEN  rs1 operand (JALR base)
pc  out  XLEN  current fetch PC
flush  out  1  squash IF/ID contents
redirect  out  1  1-cycle pulse: PC loaded with a non-sequential target
ret_addr  out  XLEN  pc_ex+4, combinational, link value for JAL/JALR
trap  out  1  1-cycle pulse: misaligned target detected
epc  out  XLEN  pc_ex of the trapping instruction, held until the next trap

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; flush, redirect and trap =0; epc=0; state=RUN; counter=0. On release the first rising edge runs normally. Reset mid-flush aborts the flush immediately.
- Targets, modulo 2^XLEN with wrap-around and no overflow flag:
  - t_br = pc_ex+imm
  - t_jal = pc_ex+imm
  - t_jalr = (rs1_d+imm) & ~1
- Request decode (RUN state, stall=0): take = jalr | jal | (br_en & b). Priority is jalr > jal > branch. br_en=1 with b=0 is not taken.
- Misaligned: the selected target has bits [1:0] != 0.
- States RUN, FLUSH; counter 3 bits.
- RUN, stall=0, no take: pc <= pc+4.
- RUN, stall=0, take and aligned:
  - pc <= target; redirect=1 for one cycle; flush=1.
  - state <= FLUSH; counter <= FLUSH_CYCLES-1.
- RUN, stall=0, take and misaligned:
  - pc <= TRAP_VEC; epc <= pc_ex; trap=1 and redirect=1 for one cycle; flush=1.
  - state <= FLUSH; counter <= FLUSH_CYCLES-1.
  - Trap outranks the normal redirect.
- FLUSH, stall=0:
  - pc <= pc+4; flush=1.
  - br_en, jal and jalr are ignored, because those instructions are wrong-path.
  - If counter==0, state <= RUN and flush <= 0 on this edge; otherwise counter decrements.
  - Total flush high time is exactly FLUSH_CYCLES cycles.
- stall=1 in any state: pc, state, counter, epc and flush hold. redirect and trap are forced 0, so a pulse never repeats. Control inputs are not sampled; upstream holds them until stall drops.
- All outputs except ret_addr are registered. Latency from EX request to new pc is one clock.
- ret_addr = pc_ex+4, combinational, wraps at 2^XLEN.
- A branch requested with br_en and jal both 1 follows jal (priority rule).

Test Plan:
- Reset/sequential: hold rst_n=0 for 3 cycles, release, 4 edges, no requests -> pc 0,4,8,12,16; flush, redirect and trap stay 0.
- Taken/not-taken: pc_ex=0x40, imm=0x20. br_en=1, b=0 -> pc=pc+4, no flush. br_en=1, b=1 -> next pc=0x60, redirect pulses 1 cycle, flush high exactly 2 cycles, a br_en=1, b=1 request during the flush is ignored.
- JALR clear-LSB and priority: rs1_d=0x1001, imm=0x4, jalr=1, jal=1, pc_ex=0x80, imm for jal context 0x100 -> pc=0x1004 (JALR wins); ret_addr=0x84.
- Misaligned trap: jal=1, pc_ex=0x200, imm=0x6 -> pc=0x100, trap=1 for one cycle, epc=0x200, flush for 2 cycles.
- Stall and wrap: pc_ex=0xFFFF_FFFC, imm=0x8, br_en=b=1 -> pc=0x4; ret_addr=0x0. Assert stall=1 for 3 cycles during FLUSH -> pc and flush frozen, redirect=0, and the flush resumes its remaining count once stall drops.
- Reset mid-flush: trigger a taken branch, pull rst_n low asynchronously mid-cycle -> pc=RESET_PC and flush=0 immediately without a clock; epc=0.

Source files
------------

// File: rtl/branch_pc_ctrl.sv
// Fetch PC owner: resolves branch/JAL/JALR redirects from EX, drives a counted
// squash of IF/ID, and vectors to TRAP_VEC when the selected target is misaligned.
module branch_pc_ctrl #(
   parameter int                 XLEN         = 32,
   parameter logic [XLEN-1:0]    RESET_PC     = 32'h0000_0000,
   parameter logic [XLEN-1:0]    TRAP_VEC     = 32'h0000_0100,
   parameter int                 FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            br_en,
   input  logic            b,
   input  logic            jal,
   input  logic            jalr,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_d,
   output logic [XLEN-1:0] pc,
   output logic            flush,
   output logic            redirect,
   output logic [XLEN-1:0] ret_addr,
   output logic            trap,
   output logic [XLEN-1:0] epc
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t          r_state, w_state_n;
   logic [2:0]      r_cnt, w_cnt_n;
   logic [XLEN-1:0] r_pc, w_pc_n;
   logic [XLEN-1:0] r_epc, w_epc_n;
   logic            r_flush, w_flush_n;
   logic            r_redirect, w_redirect_n;
   logic            r_trap, w_trap_n;

   logic [XLEN-1:0] w_t_br;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_t_jalr;
   logic [XLEN-1:0] w_target;
   logic            w_take;
   logic            w_misaligned;

   assign w_t_br       = pc_ex + imm;
   assign w_jalr_sum   = rs1_d + imm;
   assign w_t_jalr     = {w_jalr_sum[XLEN-1:1], 1'b0};
   // JAL and branch share the same pc_ex+imm target, so only JALR needs selecting
   assign w_target     = jalr ? w_t_jalr : w_t_br;
   assign w_take       = jalr | jal | (br_en & b);
   assign w_misaligned = |w_target[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_cnt      <= '0;
         r_pc       <= RESET_PC;
         r_epc      <= '0;
         r_flush    <= 1'b0;
         r_redirect <= 1'b0;
         r_trap     <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_cnt      <= w_cnt_n;
         r_pc       <= w_pc_n;
         r_epc      <= w_epc_n;
         r_flush    <= w_flush_n;
         r_redirect <= w_redirect_n;
         r_trap     <= w_trap_n;
      end
   end

   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_pc_n       = r_pc;
      w_epc_n      = r_epc;
      w_flush_n    = r_flush;
      w_redirect_n = 1'b0;
      w_trap_n     = 1'b0;
      if (!stall) begin
         unique case (r_state)
            RUN: begin
               if (w_take) begin
                  w_redirect_n = 1'b1;
                  w_flush_n    = 1'b1;
                  w_state_n    = FLUSH;
                  w_cnt_n      = CNT_LOAD;
                  if (w_misaligned) begin
                     w_pc_n   = TRAP_VEC;
                     w_epc_n  = pc_ex;
                     w_trap_n = 1'b1;
                  end else begin
                     w_pc_n = w_target;
                  end
               end else begin
                  w_pc_n = r_pc + XLEN'(4);
               end
            end
            FLUSH: begin
               // Requests seen here belong to wrong-path instructions
               w_pc_n = r_pc + XLEN'(4);
               if (r_cnt == 3'd0) begin
                  w_state_n = RUN;
                  w_flush_n = 1'b0;
               end else begin
                  w_cnt_n = r_cnt - 3'd1;
               end
            end
            default: w_state_n = RUN;
         endcase
      end
   end

   assign pc       = r_pc;
   assign flush    = r_flush;
   assign redirect = r_redirect;
   assign trap     = r_trap;
   assign epc      = r_epc;
   assign ret_addr = pc_ex + XLEN'(4);

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Scoreboard bench for branch_pc_ctrl: a reference model predicts post-edge outputs,
// each scenario task pops and compares them, plus fixed expected values per scenario.
module tb_branch_pc_ctrl;

   localparam int          FC       = 2;
   localparam logic [31:0] RST_PC   = 32'h0000_0000;
   localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, br_en = 1'b0, b = 1'b0, jal = 1'b0, jalr = 1'b0;
   logic [31:0] pc_ex = '0, imm = '0, rs1_d = '0;
   logic [31:0] pc, ret_addr, epc;
   logic        flush, redirect, trap;

   typedef struct packed {
      logic [31:0] pc;
      logic        flush;
      logic        redirect;
      logic        trap;
      logic [31:0] epc;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] m_pc, m_epc;
   int          m_left;
   int          n_cmp = 0, n_fail = 0;

   branch_pc_ctrl #(.XLEN(32), .RESET_PC(RST_PC), .TRAP_VEC(TRAP_PC), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .br_en(br_en), .b(b), .jal(jal), .jalr(jalr),
      .pc_ex(pc_ex), .imm(imm), .rs1_d(rs1_d), .pc(pc), .flush(flush), .redirect(redirect),
      .ret_addr(ret_addr), .trap(trap), .epc(epc)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_pc   = RST_PC;
      m_epc  = '0;
      m_left = 0;
      sb.delete();
   endtask

   // Predict the outputs after the coming edge, queue them, then advance one clock.
   task automatic tick();
      exp_t        x;
      logic [31:0] tgt;
      x.redirect = 1'b0;
      x.trap     = 1'b0;
      if (!stall) begin
         if (m_left > 0) begin
            m_pc   = m_pc + 32'd4;
            m_left = m_left - 1;
         end else if (jalr || jal || (br_en && b)) begin
            tgt        = jalr ? ((rs1_d + imm) & 32'hFFFF_FFFE) : (pc_ex + imm);
            m_left     = FC;
            x.redirect = 1'b1;
            if (tgt[1:0] != 2'b00) begin
               x.trap = 1'b1;
               m_pc   = TRAP_PC;
               m_epc  = pc_ex;
            end else begin
               m_pc = tgt;
            end
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
      x.pc    = m_pc;
      x.flush = (m_left > 0);
      x.epc   = m_epc;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      br_en = 1'b0; b = 1'b0; jal = 1'b0; jalr = 1'b0;
   endtask

   task automatic test_reset();
      exp_t obs;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({pc, flush, redirect, trap, epc} !== {RST_PC, 3'b000, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_state: got pc=%h fl=%b rd=%b tr=%b epc=%h, want pc=%h 0 0 0 epc=0",
                  pc, flush, redirect, trap, epc, RST_PC);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         e = sb.pop_front();
         obs = {pc, flush, redirect, trap, epc};
         n_cmp++;
         if (obs !== e || pc !== 32'(4 * i)) begin
            n_fail++;
            $display("FAIL seq_pc%0d: got %h, want %h (pc %h)", i, obs, e, 32'(4 * i));
         end
      end
   endtask

   task automatic test_branch();
      exp_t        obs;
      logic [31:0] pc0;
      int          fl_cnt;
      pc_ex = 32'h40; imm = 32'h20; br_en = 1'b1; b = 1'b0;
      pc0 = pc;
      tick();
      e = sb.pop_front();
      obs = {pc, flush, redirect, trap, epc};
      n_cmp++;
      if (obs !== e || pc !== pc0 + 32'd4 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL br_not_taken: got %h, want %h", obs, e);
      end
      b = 1'b1;
      tick();
      e = sb.pop_front();
      obs = {pc, flush, redirect, trap, epc};
      n_cmp++;
      if (obs !== e || pc !== 32'h60 || redirect !== 1'b1 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL br_taken: got %h, want %h (pc 60 redirect 1)", obs, e);
      end
      fl_cnt = 1;
      // Request left asserted during the flush must be ignored
      for (int i = 0; i < 3; i++) begin
         tick();
         if (flush === 1'b1) fl_cnt++;
         e = sb.pop_front();
         obs = {pc, flush, redirect, trap, epc};
         n_cmp++;
         if (obs !== e || redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL br_flush_%0d: got %h, want %h", i, obs, e);
         end
         if (i == 1) clear_req();
      end
      n_cmp++;
      if (fl_cnt != FC) begin
         n_fail++;
         $display("FAIL br_flush_len: got %0d cycles, want %0d", fl_cnt, FC);
      end
   endtask

   task automatic test_jalr_priority();
      exp_t obs;
      pc_ex = 32'h80; imm = 32'h4; rs1_d = 32'h1001; jal = 1'b1; jalr = 1'b1;
      #1;
      n_cmp++;
      if (ret_addr !== 32'h84) begin
         n_fail++;
         $display("FAIL jalr_ret_addr: got %h, want 00000084", ret_addr);
      end
      tick();
      e = sb.pop_front();
      obs = {pc, flush, redirect, trap, epc};
      n_cmp++;
      if (obs !== e || pc !== 32'h1004 || trap !== 1'b0) begin
         n_fail++;
         $display("FAIL jalr_target: got %h, want %h (pc 1004)", obs, e);
      end
      clear_req();
      repeat (2) begin
         tick();
         e = sb.pop_front();
         obs = {pc, flush, redirect, trap, epc};
         n_cmp++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL jalr_flush: got %h, want %h", obs, e);
         end
      end
   endtask

   task automatic test_trap();
      exp_t obs;
      pc_ex = 32'h200; imm = 32'h6; jal = 1'b1;
      tick();
      e = sb.pop_front();
      obs = {pc, flush, redirect, trap, epc};
      n_cmp++;
      if (obs !== e || pc !== TRAP_PC || trap !== 1'b1 || redirect !== 1'b1 || epc !== 32'h200) begin
         n_fail++;
         $display("FAIL trap_entry: got %h, want %h (pc 100 trap 1 epc 200)", obs, e);
      end
      clear_req();
      for (int i = 0; i < 2; i++) begin
         tick();
         e = sb.pop_front();
         obs = {pc, flush, redirect, trap, epc};
         n_cmp++;
         if (obs !== e || trap !== 1'b0 || flush !== (i == 0)) begin
            n_fail++;
            $display("FAIL trap_after_%0d: got %h, want %h", i, obs, e);
         end
      end
   endtask

   task automatic test_stall_wrap();
      exp_t obs;
      pc_ex = 32'hFFFF_FFFC; imm = 32'h8; br_en = 1'b1; b = 1'b1;
      #1;
      n_cmp++;
      if (ret_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_ret_addr: got %h, want 00000000", ret_addr);
      end
      tick();
      e = sb.pop_front();
      obs = {pc, flush, redirect, trap, epc};
      n_cmp++;
      if (obs !== e || pc !== 32'h4 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_target: got %h, want %h (pc 4)", obs, e);
      end
      clear_req();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         e = sb.pop_front();
         obs = {pc, flush, redirect, trap, epc};
         n_cmp++;
         if (obs !== e || pc !== 32'h4 || flush !== 1'b1 || redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: got %h, want %h", i, obs, e);
         end
      end
      stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         e = sb.pop_front();
         obs = {pc, flush, redirect, trap, epc};
         n_cmp++;
         if (obs !== e || flush !== (i == 0) || pc !== 32'(8 + 4 * i)) begin
            n_fail++;
            $display("FAIL stall_resume_%0d: got %h, want %h", i, obs, e);
         end
      end
      // A request arriving under stall must neither move pc nor pulse redirect
      jal = 1'b1; pc_ex = 32'h300; imm = 32'h10; stall = 1'b1;
      tick();
      e = sb.pop_front();
      obs = {pc, flush, redirect, trap, epc};
      n_cmp++;
      if (obs !== e || redirect !== 1'b0 || pc !== 32'hC) begin
         n_fail++;
         $display("FAIL stall_req: got %h, want %h", obs, e);
      end
      stall = 1'b0;
      tick();
      e = sb.pop_front();
      obs = {pc, flush, redirect, trap, epc};
      n_cmp++;
      if (obs !== e || pc !== 32'h310 || redirect !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release_req: got %h, want %h", obs, e);
      end
      clear_req();
      repeat (2) begin
         tick();
         void'(sb.pop_front());
      end
   endtask

   task automatic test_reset_mid_flush();
      exp_t obs;
      pc_ex = 32'h40; imm = 32'h20; br_en = 1'b1; b = 1'b1;
      tick();
      e = sb.pop_front();
      obs = {pc, flush, redirect, trap, epc};
      n_cmp++;
      if (obs !== e || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL rmf_taken: got %h, want %h", obs, e);
      end
      clear_req();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({pc, flush, redirect, trap, epc} !== {RST_PC, 3'b000, 32'h0}) begin
         n_fail++;
         $display("FAIL rmf_async: got pc=%h fl=%b rd=%b tr=%b epc=%h, want pc=%h 0 0 0 epc=0",
                  pc, flush, redirect, trap, epc, RST_PC);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      e = sb.pop_front();
      obs = {pc, flush, redirect, trap, epc};
      n_cmp++;
      if (obs !== e || pc !== RST_PC + 32'd4 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL rmf_restart: got %h, want %h", obs, e);
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_jalr_priority();
      test_trap();
      test_stall_wrap();
      test_reset_mid_flush();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
